// File: rtl/bram_port_arbiter_if.sv
// Handshake bundle between the two BRAM requesters and the port arbiter.
// master = requester side (accumulation unit / AXI read engine), slave = arbiter.
interface bram_port_arbiter_if #(
    parameter int CNT_W = 7
);
    logic             acc_req;
    logic             acc_done;
    logic             ext_req;
    logic             ext_done;
    logic             acc_gnt;
    logic             ext_gnt;
    logic             mux_sel;
    logic             acc_preempt;
    logic             busy;
    logic [CNT_W-1:0] burst_cnt;

    modport master (
        output acc_req,
        output acc_done,
        output ext_req,
        output ext_done,
        input  acc_gnt,
        input  ext_gnt,
        input  mux_sel,
        input  acc_preempt,
        input  busy,
        input  burst_cnt
    );

    modport slave (
        input  acc_req,
        input  acc_done,
        input  ext_req,
        input  ext_done,
        output acc_gnt,
        output ext_gnt,
        output mux_sel,
        output acc_preempt,
        output busy,
        output burst_cnt
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Arbitrates the weight-BRAM port bank between accumulation (sel 0) and external reads (sel 1).
// Latency: grant 1 cycle after request if mux already points at the winner, else 2 (turnaround).
// Backpressure: requesters hold req until granted; accumulation is force-released after MAX_BURST cycles.
module bram_port_arbiter #(
    parameter int MAX_BURST = 64,
    parameter int CNT_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TURN    = 2'd1,
        ST_OWN_ACC = 2'd2,
        ST_OWN_EXT = 2'd3
    } state_e;

    // Owner encoding matches the mux select value.
    typedef enum logic {
        OWNER_ACC = 1'b0,
        OWNER_EXT = 1'b1
    } owner_e;

    state_e           state_q, state_d;
    owner_e           target_q, target_d;
    owner_e           last_owner_q, last_owner_d;
    owner_e           mux_sel_q, mux_sel_d;
    owner_e           winner;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] burst_cnt_inc;
    logic             preempt_q, preempt_d;
    logic             at_limit;
    logic             acc_limit_hit;
    logic             acc_release;
    logic             ext_release;

    assign burst_cnt_inc = (burst_cnt_q == CNT_W'(MAX_BURST)) ? burst_cnt_q
                                                              : burst_cnt_q + CNT_W'(1);
    assign at_limit      = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    // Preemption only counts when the burst limit is the sole reason for letting go.
    assign acc_limit_hit = at_limit && bus.ext_req && bus.acc_req && !bus.acc_done;
    assign acc_release   = bus.acc_done || !bus.acc_req || (at_limit && bus.ext_req);
    assign ext_release   = bus.ext_done || !bus.ext_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            target_q     <= OWNER_ACC;
            last_owner_q <= OWNER_EXT;
            mux_sel_q    <= OWNER_ACC;
            burst_cnt_q  <= '0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            last_owner_q <= last_owner_d;
            mux_sel_q    <= mux_sel_d;
            burst_cnt_q  <= burst_cnt_d;
            preempt_q    <= preempt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        last_owner_d = last_owner_q;
        mux_sel_d    = mux_sel_q;
        burst_cnt_d  = '0;
        preempt_d    = 1'b0;
        winner       = OWNER_ACC;

        case (state_q)
            ST_IDLE: begin
                if (bus.acc_req || bus.ext_req) begin
                    if (bus.acc_req && bus.ext_req) begin
                        winner = (last_owner_q == OWNER_ACC) ? OWNER_EXT : OWNER_ACC;
                    end else begin
                        winner = bus.ext_req ? OWNER_EXT : OWNER_ACC;
                    end
                    target_d = winner;
                    if (mux_sel_q == winner) begin
                        state_d = (winner == OWNER_EXT) ? ST_OWN_EXT : ST_OWN_ACC;
                    end else begin
                        mux_sel_d = winner;
                        state_d   = ST_TURN;
                    end
                end
            end

            ST_TURN: begin
                state_d = (target_q == OWNER_EXT) ? ST_OWN_EXT : ST_OWN_ACC;
            end

            ST_OWN_ACC: begin
                if (acc_release) begin
                    last_owner_d = OWNER_ACC;
                    preempt_d    = acc_limit_hit;
                    if (bus.ext_req) begin
                        mux_sel_d = OWNER_EXT;
                        target_d  = OWNER_EXT;
                        state_d   = ST_TURN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_inc;
                end
            end

            ST_OWN_EXT: begin
                if (ext_release) begin
                    last_owner_d = OWNER_EXT;
                    if (bus.acc_req) begin
                        mux_sel_d = OWNER_ACC;
                        target_d  = OWNER_ACC;
                        state_d   = ST_TURN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    burst_cnt_d = burst_cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.acc_gnt     = (state_q == ST_OWN_ACC);
    assign bus.ext_gnt     = (state_q == ST_OWN_EXT);
    assign bus.mux_sel     = mux_sel_q;
    assign bus.acc_preempt = preempt_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.burst_cnt   = burst_cnt_q;

endmodule
